dot_seq: RTL and testbench
==========================

# dot_seq

Sequencer that computes the fixpoint dot product of two long vectors by streaming them in VEC_SIZE-element chunks through one `vec_mul` instance. It accumulates each chunk's `o_dot` into a running sum and returns the total over a valid/ready handshake. It sits between a vector source (DMA or register file streamer) and any consumer of scalar fixpoint results.

## Interface
- `VEC_SIZE`, 16: lanes per chunk; passed to `vec_mul`.
- `LEN_W`, 16: width of the chunk-count field.
- `i_clk` in, 1: sole clock.
- `i_rst` in, 1: synchronous, active-high reset.
- `i_start_valid` in, 1: command valid.
- `o_start_ready` out, 1: command accepted when both high.
- `i_len` in, LEN_W: number of chunks in the job; sampled on command accept.
- `i_chunk_valid` in, 1: chunk beat valid.
- `o_chunk_ready` out, 1: chunk beat accepted when both high.
- `i_chunk_a` in, VEC_SIZE×`FIXPOINT_WIDTH`: operand A chunk.
- `i_chunk_b` in, VEC_SIZE×`FIXPOINT_WIDTH`: operand B chunk.
- `o_res_valid` out, 1: result valid.
- `i_res_ready` in, 1: result consumed when both high.
- `o_res` out, `FIXPOINT_WIDTH`: accumulated dot product.
- `o_busy` out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `o_start_ready`=1. On accept, the accumulator clears to 0 and the remaining-chunk counter loads `i_len`.
  - If `i_len`==0, go to DONE with `o_res`=0. Otherwise go to RUN.
- RUN:
  - `o_chunk_ready`=1.
  - Each accepted beat drives `vec_mul` with the chunk, adds its `o_dot` to the accumulator with `fixpoint_add`, and decrements the counter.
  - Beats are ignored while `i_chunk_valid`=0; state, counter and accumulator hold.
  - On the beat that takes the counter from 1 to 0: go to DRAIN if `DOT_SEQ_PIPE_EN` is defined, otherwise go to DONE.
- DRAIN: one cycle. `o_chunk_ready`=0. The pending pipelined product is added. Then go to DONE.
- DONE:
  - `o_res_valid`=1 and `o_res`=accumulator, both held stable until `i_res_ready`.
  - On handshake, go to IDLE.
  - A new command cannot be accepted in the same cycle as the result handshake.
- Arithmetic:
  - Accumulation uses `fixpoint_add` only, in chunk order, starting from 0.
  - Each per-chunk value is `vec_mul`'s `o_dot`, whose lane summation order is fixed by `vec_mul`.
  - No widening: the accumulator is `FIXPOINT_WIDTH` bits.
- Handshake signals outside their own state are 0: `o_start_ready` outside IDLE, `o_chunk_ready` outside RUN, `o_res_valid` outside DONE.
- Reset (any cycle, including mid-job or with a result pending): state→IDLE and the job is discarded.

## Timing
- Reset values:
  - `o_start_ready`=1 (state is IDLE).
  - `o_chunk_ready`=0.
  - `o_res_valid`=0.
  - `o_res`=0.
  - `o_busy`=0.
  - Counter=0, accumulator=0.
- Throughput: one chunk per cycle in RUN.
- Without the macro, latency from the last chunk accept to `o_res_valid` is 1 cycle.
- With the macro, that latency is 2 cycles.
- `i_len`==0: `o_res_valid` is asserted 1 cycle after the command accept.
- Minimum command-to-command spacing: the result handshake cycle plus one IDLE cycle.

## Configuration
- `DOT_SEQ_PIPE_EN`:
  - Defined: a register stage sits between `vec_mul.o_dot` and the accumulator adder, which breaks the multiply-tree/add path. The DRAIN state is used and latency is +1.
  - Undefined: the accumulator adds `o_dot` combinationally in the accept cycle, and DRAIN is never entered.
  - Results are bit-identical in both builds.

## Structure
- `dot_seq_pkg`: state enum `dot_seq_state_t` (IDLE, RUN, DRAIN, DONE), and the default `LEN_W` constant.
- Fixpoint width and functions come from `fixpoint.svh`.
- One sub-module: `vec_mul`, instantiated once. Only its `o_dot` output is used; `o_vec_mul` and `o_vec_add` are left unconnected.

## Test plan
Lane values below are real numbers in fixpoint encoding.
1. Single chunk, length 1: all lanes a=1.0, b=2.0 → `o_res`=32.0, `o_res_valid` high 1 cycle after the chunk (2 cycles with the macro).
2. Length 4, streamed back-to-back. Chunk k has all lanes a=k+1, b=0.5 → `o_res`=8·(1+2+3+4)=80.0. `o_chunk_ready` stays high for exactly 4 accepted beats.
3. Zero length: `i_len`=0 → `o_res`=0 with `o_res_valid` 1 cycle after accept. `o_chunk_ready` never asserts.
4. Source bubbles and result backpressure: `i_len`=3 with `i_chunk_valid` gapped, and `i_res_ready` held low 5 cycles.
   - Result equals the gapless run.
   - `o_res` is stable while stalled.
   - `o_start_ready`=0 until after the result handshake.
5. Reset mid-job: assert `i_rst` after 2 of 4 chunks. All outputs return to reset values next cycle. A new `i_len`=1 job then returns only its own product, e.g. 16.0 for a=b=1.0.
6. Signed values: a=-1.0, b=3.0 in all lanes, `i_len`=2 → `o_res`=-96.0.

Source files
------------

// File: rtl/dot_seq_pkg.sv
// Shared types for the dot_seq chunked dot-product sequencer.
package dot_seq_pkg;
   localparam int DOT_SEQ_LEN_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } dot_seq_state_t;
endpackage

// File: rtl/fixpoint.svh
// Signed fixpoint format (Q16.16 unless FIXPOINT_WIDTH/FIXPOINT_FRAC are predefined)
// and the saturating add/multiply helpers shared by the datapath.
`ifndef FIXPOINT_SVH
`define FIXPOINT_SVH

`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 32
`endif
`ifndef FIXPOINT_FRAC
`define FIXPOINT_FRAC 16
`endif

package fixpoint;
   localparam int FW   = `FIXPOINT_WIDTH;
   localparam int FRAC = `FIXPOINT_FRAC;

   typedef logic signed [FW-1:0]   fixpoint_t;
   typedef logic signed [2*FW-1:0] fixpoint_wide_t;

   function automatic fixpoint_t fixpoint_sat(input fixpoint_wide_t v);
      fixpoint_wide_t max_v;
      fixpoint_wide_t min_v;
      max_v = {{(FW+1){1'b0}}, {(FW-1){1'b1}}};
      min_v = {{(FW+1){1'b1}}, {(FW-1){1'b0}}};
      if (v > max_v) begin
         return max_v[FW-1:0];
      end else if (v < min_v) begin
         return min_v[FW-1:0];
      end
      return v[FW-1:0];
   endfunction

   function automatic fixpoint_t fixpoint_add(input fixpoint_t a, input fixpoint_t b);
      fixpoint_wide_t s;
      s = fixpoint_wide_t'(a) + fixpoint_wide_t'(b);
      return fixpoint_sat(s);
   endfunction

   // Product is floored back to the fractional scale before clamping.
   function automatic fixpoint_t fixpoint_mul(input fixpoint_t a, input fixpoint_t b);
      fixpoint_wide_t p;
      p = fixpoint_wide_t'(a) * fixpoint_wide_t'(b);
      return fixpoint_sat(p >>> FRAC);
   endfunction
endpackage

`endif

// File: rtl/vec_mul.sv
// Lane-wise fixpoint multiply/add of two VEC_SIZE vectors plus their dot product,
// summed strictly from lane 0 upward so saturation behaviour is deterministic.
`include "fixpoint.svh"

module vec_mul
   import fixpoint::*;
#(
   parameter int VEC_SIZE = 16
) (
   input  logic [VEC_SIZE*`FIXPOINT_WIDTH-1:0] i_a,
   input  logic [VEC_SIZE*`FIXPOINT_WIDTH-1:0] i_b,
   output logic [VEC_SIZE*`FIXPOINT_WIDTH-1:0] o_vec_mul,
   output logic [VEC_SIZE*`FIXPOINT_WIDTH-1:0] o_vec_add,
   output logic [`FIXPOINT_WIDTH-1:0]          o_dot
);

   always_comb begin
      o_vec_mul = '0;
      o_vec_add = '0;
      o_dot     = '0;
      for (int i = 0; i < VEC_SIZE; i++) begin
         o_vec_mul[i*FW +: FW] = fixpoint_mul(i_a[i*FW +: FW], i_b[i*FW +: FW]);
         o_vec_add[i*FW +: FW] = fixpoint_add(i_a[i*FW +: FW], i_b[i*FW +: FW]);
         o_dot = fixpoint_add(o_dot, o_vec_mul[i*FW +: FW]);
      end
   end

endmodule

// File: rtl/dot_seq.sv
// Streams long vectors through one vec_mul a chunk at a time and accumulates the total.
// Optional DOT_SEQ_PIPE_EN registers o_dot before the accumulator (adds a DRAIN cycle).
`include "fixpoint.svh"

module dot_seq
   import dot_seq_pkg::*;
   import fixpoint::*;
#(
   parameter int VEC_SIZE = 16,
   parameter int LEN_W    = DOT_SEQ_LEN_W
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_start_valid,
   output logic                                o_start_ready,
   input  logic [LEN_W-1:0]                    i_len,
   input  logic                                i_chunk_valid,
   output logic                                o_chunk_ready,
   input  logic [VEC_SIZE*`FIXPOINT_WIDTH-1:0] i_chunk_a,
   input  logic [VEC_SIZE*`FIXPOINT_WIDTH-1:0] i_chunk_b,
   output logic                                o_res_valid,
   input  logic                                i_res_ready,
   output logic [`FIXPOINT_WIDTH-1:0]          o_res,
   output logic                                o_busy
);

   dot_seq_state_t state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   fixpoint_t acc_q, acc_d;
   fixpoint_t dot_p0;
   logic [VEC_SIZE*FW-1:0] vec_mul_unused;
   logic [VEC_SIZE*FW-1:0] vec_add_unused;

   vec_mul #(
      .VEC_SIZE(VEC_SIZE)
   ) u_vec_mul (
      .i_a      (i_chunk_a),
      .i_b      (i_chunk_b),
      .o_vec_mul(vec_mul_unused),
      .o_vec_add(vec_add_unused),
      .o_dot    (dot_p0)
   );

`ifdef DOT_SEQ_PIPE_EN
   // Stage p0 -> p1: chunk product registered ahead of the accumulator adder.
   fixpoint_t prod_p1_q, prod_p1_d;
   logic vld_p1_q, vld_p1_d;

   always_ff @(posedge i_clk) begin
      prod_p1_q <= prod_p1_d;
      if (i_rst) begin
         vld_p1_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
      end
   end
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      o_start_ready = 1'b0;
      o_chunk_ready = 1'b0;
      o_res_valid   = 1'b0;
`ifdef DOT_SEQ_PIPE_EN
      vld_p1_d  = 1'b0;
      prod_p1_d = dot_p0;
      if (vld_p1_q) begin
         acc_d = fixpoint_add(acc_q, prod_p1_q);
      end
`endif
      unique case (state_q)
         IDLE: begin
            o_start_ready = 1'b1;
            if (i_start_valid) begin
               acc_d = '0;
               cnt_d = i_len;
               if (i_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            o_chunk_ready = 1'b1;
            if (i_chunk_valid) begin
               cnt_d = cnt_q - LEN_W'(1);
`ifdef DOT_SEQ_PIPE_EN
               vld_p1_d = 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  state_d = DRAIN;
               end
`else
               acc_d = fixpoint_add(acc_q, dot_p0);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = DONE;
               end
`endif
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            o_res_valid = 1'b1;
            if (i_res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   assign o_res  = acc_q;
   assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_dot_seq.sv
// Randomised bench for dot_seq; an arithmetic reference model scores every result presented.
`include "fixpoint.svh"

module tb_dot_seq;
   localparam int VS   = 16;
   localparam int LW   = 16;
   localparam int FW   = `FIXPOINT_WIDTH;
   localparam int FRAC = `FIXPOINT_FRAC;
`ifdef DOT_SEQ_PIPE_EN
   localparam int EXP_LAT = 2;
`else
   localparam int EXP_LAT = 1;
`endif
   localparam longint ONE = longint'(1) <<< FRAC;

   typedef logic [VS*FW-1:0] chunk_t;

   logic                 i_clk = 1'b0;
   logic                 i_rst;
   logic                 i_start_valid;
   logic                 o_start_ready;
   logic [LW-1:0]        i_len;
   logic                 i_chunk_valid;
   logic                 o_chunk_ready;
   chunk_t               i_chunk_a;
   chunk_t               i_chunk_b;
   logic                 o_res_valid;
   logic                 i_res_ready;
   logic signed [FW-1:0] o_res;
   logic                 o_busy;

   int checks   = 0;
   int failures = 0;

   chunk_t ca[$];
   chunk_t cb[$];
   logic signed [FW-1:0] exp_q[$];

   dot_seq #(.VEC_SIZE(VS), .LEN_W(LW)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start_valid(i_start_valid),
      .o_start_ready(o_start_ready),
      .i_len        (i_len),
      .i_chunk_valid(i_chunk_valid),
      .o_chunk_ready(o_chunk_ready),
      .i_chunk_a    (i_chunk_a),
      .i_chunk_b    (i_chunk_b),
      .o_res_valid  (o_res_valid),
      .i_res_ready  (i_res_ready),
      .o_res        (o_res),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference arithmetic: saturate to the signed fixpoint range.
   function automatic longint clamp(input longint v);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (FW - 1)) - 1;
      lo = -(longint'(1) <<< (FW - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint lane(input chunk_t c, input int i);
      logic signed [FW-1:0] v;
      v = c[i*FW +: FW];
      return longint'(v);
   endfunction

   function automatic longint chunk_dot(input chunk_t a, input chunk_t b);
      longint s;
      s = 0;
      for (int i = 0; i < VS; i++) begin
         s = clamp(s + clamp((lane(a, i) * lane(b, i)) >>> FRAC));
      end
      return s;
   endfunction

   function automatic longint job_total(input int len);
      longint s;
      s = 0;
      for (int k = 0; k < len; k++) begin
         s = clamp(s + chunk_dot(ca[k], cb[k]));
      end
      return s;
   endfunction

   function automatic chunk_t splat(input longint v);
      chunk_t c;
      logic [63:0] t;
      t = v;
      for (int i = 0; i < VS; i++) c[i*FW +: FW] = t[FW-1:0];
      return c;
   endfunction

   function automatic chunk_t rand_chunk();
      chunk_t c;
      logic [63:0] t;
      for (int i = 0; i < VS; i++) begin
         t = longint'($signed($urandom)) >>> $urandom_range(4, 20);
         c[i*FW +: FW] = t[FW-1:0];
      end
      return c;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_start_ready"}, o_start_ready, 1);
      chk({tag, "_chunk_ready"}, o_chunk_ready, 0);
      chk({tag, "_res_valid"}, o_res_valid, 0);
      chk({tag, "_res"}, o_res, 0);
      chk({tag, "_busy"}, o_busy, 0);
   endtask

   // One complete job: command, chunk stream (optionally gapped), latency, backpressure, handshake.
   task automatic do_job(input int len, input bit gaps, input int bp, output logic signed [FW-1:0] got);
      int guard;
      int sent;
      int lat;
      bit acc;
      longint e;
      e = job_total(len);
      exp_q.push_back(e[FW-1:0]);
      guard = 0;
      while (!o_start_ready && guard < 50) begin
         @(posedge i_clk); #1;
         guard++;
      end
      chk("start_ready_wait", o_start_ready, 1);
      i_len = LW'(len);
      i_start_valid = 1'b1;
      @(posedge i_clk); #1;
      i_start_valid = 1'b0;
      chk("busy_after_start", o_busy, 1);
      sent = 0;
      guard = 0;
      while (sent < len && guard < 2000) begin
         if (gaps && (guard % 2 == 0)) begin
            i_chunk_valid = 1'b0;
         end else begin
            i_chunk_valid = 1'b1;
            i_chunk_a = ca[sent];
            i_chunk_b = cb[sent];
         end
         acc = i_chunk_valid && o_chunk_ready;
         @(posedge i_clk); #1;
         guard++;
         if (acc) sent++;
      end
      i_chunk_valid = 1'b0;
      chk("beats_accepted", sent, len);
      chk("chunk_ready_after_last", o_chunk_ready, 0);
      lat = 1;
      while (!o_res_valid && lat < 20) begin
         @(posedge i_clk); #1;
         lat++;
      end
      chk("result_latency", lat, (len == 0) ? 1 : EXP_LAT);
      got = o_res;
      for (int c = 0; c < bp; c++) begin
         chk("stall_start_ready", o_start_ready, 0);
         chk("stall_res_valid", o_res_valid, 1);
         chk("stall_res_stable", o_res, got);
         @(posedge i_clk); #1;
      end
      i_res_ready = 1'b1;
      @(posedge i_clk); #1;
      i_res_ready = 1'b0;
      chk("after_hs_res_valid", o_res_valid, 0);
      chk("after_hs_start_ready", o_start_ready, 1);
      chk("after_hs_busy", o_busy, 0);
   endtask

   // Continuous scoring against the model on the falling edge.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         chk("start_ready_is_idle", o_start_ready, !o_busy);
         chk("chunk_res_exclusive", o_chunk_ready && o_res_valid, 0);
         if (o_res_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               chk("res_vs_model", o_res, exp_q[0]);
               if (i_res_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic signed [FW-1:0] got;
      int len;
      i_rst = 1'b1;
      i_start_valid = 1'b0;
      i_len = '0;
      i_chunk_valid = 1'b0;
      i_chunk_a = '0;
      i_chunk_b = '0;
      i_res_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk_reset_outputs("reset");
      i_rst = 1'b0;

      // Single chunk: 16 lanes of 1.0*2.0.
      ca.delete(); cb.delete();
      ca.push_back(splat(ONE)); cb.push_back(splat(2 * ONE));
      chk("model_single", job_total(1), 32 * ONE);
      do_job(1, 1'b0, 0, got);
      chk("single_res", got, 32 * ONE);

      // Four back-to-back chunks, a=k+1, b=0.5.
      ca.delete(); cb.delete();
      for (int k = 0; k < 4; k++) begin
         ca.push_back(splat((k + 1) * ONE));
         cb.push_back(splat(ONE / 2));
      end
      chk("model_len4", job_total(4), 80 * ONE);
      do_job(4, 1'b0, 2, got);
      chk("len4_res", got, 80 * ONE);

      // Zero-length job.
      do_job(0, 1'b0, 1, got);
      chk("zero_len_res", got, 0);

      // Same three chunks gapless, then gapped with 5 cycles of backpressure.
      ca.delete(); cb.delete();
      for (int k = 0; k < 3; k++) begin
         ca.push_back(rand_chunk());
         cb.push_back(rand_chunk());
      end
      do_job(3, 1'b0, 0, got);
      do_job(3, 1'b1, 5, got);

      // Reset after 2 of 4 chunks, then a fresh length-1 job.
      ca.delete(); cb.delete();
      for (int k = 0; k < 4; k++) begin
         ca.push_back(splat(ONE));
         cb.push_back(splat(ONE));
      end
      i_len = LW'(4);
      i_start_valid = 1'b1;
      @(posedge i_clk); #1;
      i_start_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_chunk_valid = 1'b1;
         i_chunk_a = ca[k];
         i_chunk_b = cb[k];
         @(posedge i_clk); #1;
      end
      i_chunk_valid = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      chk_reset_outputs("midjob_reset");
      i_rst = 1'b0;
      do_job(1, 1'b0, 0, got);
      chk("post_reset_res", got, 16 * ONE);

      // Signed operands: -1.0 * 3.0 over two chunks.
      ca.delete(); cb.delete();
      for (int k = 0; k < 2; k++) begin
         ca.push_back(splat(-ONE));
         cb.push_back(splat(3 * ONE));
      end
      chk("model_signed", job_total(2), -96 * ONE);
      do_job(2, 1'b0, 0, got);
      chk("signed_res", got, -96 * ONE);

      // Randomised jobs.
      for (int j = 0; j < 12; j++) begin
         len = $urandom_range(0, 6);
         ca.delete(); cb.delete();
         for (int k = 0; k < len; k++) begin
            ca.push_back(rand_chunk());
            cb.push_back(rand_chunk());
         end
         do_job(len, 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
      end

      repeat (2) @(posedge i_clk);
      chk("model_queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
